// File: rtl/riscv_fetch_pkg.sv
// Shared types and constants for the multicycle RISC-V instruction-fetch stage.
// Holds the fetch FSM state encoding, the reset nop, and small PC helpers.
package riscv_fetch_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  typedef enum logic [2:0] {
    BOOT = 3'd0,
    REQ  = 3'd1,
    WAIT = 3'd2,
    HOLD = 3'd3,
    ERR  = 3'd4
  } fetch_state_e;

  function automatic logic is_word_aligned(input logic [XLEN-1:0] addr);
    return addr[1:0] == 2'b00;
  endfunction

  // Sequential PC step; wraps modulo 2^32 by construction.
  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] addr);
    return addr + 32'd4;
  endfunction

endpackage

// File: rtl/riscv_fetch_if.sv
// Instruction-memory request/response and datapath instruction handshake.
// The fetch stage is the master; memory plus datapath together form the slave side.
interface riscv_fetch_if;
  import riscv_fetch_pkg::*;

  logic            imem_req;
  logic [XLEN-1:0] imem_addr;
  logic            imem_rvalid;
  logic [XLEN-1:0] imem_rdata;

  logic            instr_valid;
  logic            instr_ready;
  logic [XLEN-1:0] instr;
  logic [XLEN-1:0] instr_pc;

  modport master (
    output imem_req, imem_addr, instr_valid, instr, instr_pc,
    input  imem_rvalid, imem_rdata, instr_ready
  );

  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, instr_pc,
    output imem_rvalid, imem_rdata, instr_ready
  );

endinterface

// File: rtl/riscv_fetch.sv
// Multicycle fetch stage: owns the PC, issues one instruction-memory request at a time,
// presents each word to the datapath and discards responses made stale by redirects.
module riscv_fetch
  import riscv_fetch_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             redirect,
  input  logic [XLEN-1:0]  redirect_pc,
  output logic [XLEN-1:0]  pc,
  output logic             fetch_err,
  riscv_fetch_if.master    bus
);

  fetch_state_e    state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            kill_q, kill_d;
  logic [XLEN-1:0] instr_q;
  logic [XLEN-1:0] instr_pc_q;
  logic            capture;
  logic            redirect_ok;
  logic            redirect_bad;

  assign redirect_ok  = redirect &&  is_word_aligned(redirect_pc);
  assign redirect_bad = redirect && !is_word_aligned(redirect_pc);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= BOOT;
      pc_q       <= RESET_PC;
      kill_q     <= 1'b0;
      instr_q    <= NOP_INSTR;
      instr_pc_q <= RESET_PC;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      kill_q  <= kill_d;
      if (capture) begin
        instr_q    <= bus.imem_rdata;
        instr_pc_q <= pc_q;
      end
    end
  end

  // A misaligned redirect traps without touching the PC; an aligned one beats both
  // instr_ready and the sequential step. kill marks the outstanding request as stale.
  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    kill_d  = kill_q;
    capture = 1'b0;
    case (state_q)
      BOOT: state_d = REQ;
      REQ: begin
        if (redirect_bad) begin
          state_d = ERR;
          kill_d  = 1'b0;
        end else if (redirect_ok) begin
          pc_d    = redirect_pc;
          kill_d  = 1'b1;
          state_d = WAIT;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (redirect_bad) begin
          state_d = ERR;
          kill_d  = 1'b0;
        end else if (redirect_ok) begin
          pc_d = redirect_pc;
          if (bus.imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d = 1'b1;
          end
        end else if (bus.imem_rvalid) begin
          if (kill_q) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            capture = 1'b1;
            state_d = HOLD;
          end
        end
      end
      HOLD: begin
        if (redirect_bad) begin
          state_d = ERR;
        end else if (redirect_ok) begin
          pc_d    = redirect_pc;
          state_d = REQ;
        end else if (bus.instr_ready) begin
          pc_d    = pc_plus4(pc_q);
          state_d = REQ;
        end
      end
      ERR:     state_d = ERR;
      default: state_d = BOOT;
    endcase
  end

  assign bus.imem_req    = (state_q == REQ);
  assign bus.imem_addr   = pc_q;
  assign bus.instr_valid = (state_q == HOLD);
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign pc              = pc_q;
  assign fetch_err       = (state_q == ERR);

endmodule

// File: tb/tb_riscv_fetch.sv
// Directed bench for riscv_fetch: a vector table for sequential fetch, then hand-written
// sequences for redirects, stalls, slow memory, misaligned targets and mid-fetch reset.
module tb_riscv_fetch;
  import riscv_fetch_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] pc;
  logic        fetch_err;
  int          n_checks = 0;
  int          n_fail = 0;

  riscv_fetch_if bus();

  riscv_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst(rst), .redirect(redirect), .redirect_pc(redirect_pc),
    .pc(pc), .fetch_err(fetch_err), .bus(bus)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        rvalid;
    logic [31:0] rdata;
    logic        ready;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_valid;
    logic [31:0] exp_instr;
    logic [31:0] exp_ipc;
    logic [31:0] exp_pc;
    logic        exp_err;
  } vec_t;

  vec_t vectors[11];

  task automatic applyStimulus(input logic rd, input logic [31:0] rpc, input logic rv,
                               input logic [31:0] rdat, input logic rdy);
    redirect         = rd;
    redirect_pc      = rpc;
    bus.imem_rvalid  = rv;
    bus.imem_rdata   = rdat;
    bus.instr_ready  = rdy;
  endtask

  task automatic checkField(input string tag, input string field,
                            input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s.%s actual=%h expected=%h", tag, field, actual, expected);
    end
  endtask

  task automatic checkOutput(input string tag, input logic req, input logic [31:0] addr,
                             input logic valid, input logic [31:0] ins, input logic [31:0] ipc,
                             input logic [31:0] epc, input logic err);
    checkField(tag, "imem_req",    {31'd0, bus.imem_req},    {31'd0, req});
    checkField(tag, "imem_addr",   bus.imem_addr,            addr);
    checkField(tag, "instr_valid", {31'd0, bus.instr_valid}, {31'd0, valid});
    checkField(tag, "instr",       bus.instr,                ins);
    checkField(tag, "instr_pc",    bus.instr_pc,             ipc);
    checkField(tag, "pc",          pc,                       epc);
    checkField(tag, "fetch_err",   {31'd0, fetch_err},       {31'd0, err});
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic resetDut();
    rst = 1'b1;
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    repeat (2) @(negedge clk);
    checkOutput("in_reset", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 1'b0);
    rst = 1'b0;
  endtask

  initial begin
    // Sequential fetch from RESET_PC=0 with a zero-wait memory and instr_ready held high.
    vectors[0]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b0, NOP_INSTR,     32'h0, 32'h0, 1'b0};
    vectors[1]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h0, 1'b0, NOP_INSTR,     32'h0, 32'h0, 1'b0};
    vectors[2]  = '{1'b0, 32'h0, 1'b1, 32'h0000_0013, 1'b1, 1'b0, 32'h0, 1'b0, NOP_INSTR,     32'h0, 32'h0, 1'b0};
    vectors[3]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h0, 1'b1, 32'h0000_0013, 32'h0, 32'h0, 1'b0};
    vectors[4]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h4, 1'b0, 32'h0000_0013, 32'h0, 32'h4, 1'b0};
    vectors[5]  = '{1'b0, 32'h0, 1'b1, 32'h0010_0093, 1'b1, 1'b0, 32'h4, 1'b0, 32'h0000_0013, 32'h0, 32'h4, 1'b0};
    vectors[6]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h4, 1'b1, 32'h0010_0093, 32'h4, 32'h4, 1'b0};
    vectors[7]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b1, 32'h8, 1'b0, 32'h0010_0093, 32'h4, 32'h8, 1'b0};
    vectors[8]  = '{1'b0, 32'h0, 1'b1, 32'h0020_0113, 1'b1, 1'b0, 32'h8, 1'b0, 32'h0010_0093, 32'h4, 32'h8, 1'b0};
    vectors[9]  = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b1, 1'b0, 32'h8, 1'b1, 32'h0020_0113, 32'h8, 32'h8, 1'b0};
    vectors[10] = '{1'b0, 32'h0, 1'b0, 32'h0,         1'b0, 1'b1, 32'hC, 1'b0, 32'h0020_0113, 32'h8, 32'hC, 1'b0};

    resetDut();
    for (int i = 0; i < 11; i++) begin
      checkOutput($sformatf("vec%0d", i), vectors[i].exp_req, vectors[i].exp_addr,
                  vectors[i].exp_valid, vectors[i].exp_instr, vectors[i].exp_ipc,
                  vectors[i].exp_pc, vectors[i].exp_err);
      applyStimulus(vectors[i].redirect, vectors[i].redirect_pc, vectors[i].rvalid,
                    vectors[i].rdata, vectors[i].ready);
      step();
    end

    // jal at address 0 redirects to 12 while held; redirect beats instr_ready.
    resetDut();
    checkOutput("jal_boot", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step();
    checkOutput("jal_req", 1'b1, 32'h0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 1'b0);
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h00c0_00ef, 1'b0); step();
    checkOutput("jal_hold", 1'b0, 32'h0, 1'b1, 32'h00c0_00ef, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b1, 32'd12, 1'b0, 32'h0, 1'b1); step();
    checkOutput("jal_target", 1'b1, 32'd12, 1'b0, 32'h00c0_00ef, 32'h0, 32'd12, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h1110_0093, 1'b0); step();

    // Back-pressure: five stalled cycles keep everything frozen.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("stall%0d", i), 1'b0, 32'd12, 1'b1, 32'h1110_0093, 32'd12, 32'd12, 1'b0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    checkOutput("stall_release", 1'b1, 32'd16, 1'b0, 32'h1110_0093, 32'd12, 32'd16, 1'b0);

    // Four-cycle memory with a redirect to 20 in WAIT: the late word is discarded.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step();
    applyStimulus(1'b1, 32'd20, 1'b0, 32'h0, 1'b0); step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      checkOutput($sformatf("kill_wait%0d", i), 1'b0, 32'd20, 1'b0, 32'h1110_0093, 32'd12, 32'd20, 1'b0);
      step();
    end
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, 1'b1); step();
    checkOutput("kill_drop", 1'b1, 32'd20, 1'b0, 32'h1110_0093, 32'd12, 32'd20, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0050_0093, 1'b0); step();
    checkOutput("kill_refetch", 1'b0, 32'd20, 1'b1, 32'h0050_0093, 32'd20, 32'd20, 1'b0);

    // Redirect in REQ kills the issued request.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    applyStimulus(1'b1, 32'd40, 1'b0, 32'h0, 1'b0); step();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hBAD0_0BAD, 1'b0); step();
    checkOutput("req_kill", 1'b1, 32'd40, 1'b0, 32'h0050_0093, 32'd20, 32'd40, 1'b0);

    // Redirect coinciding with rvalid, then the PC wraps past 0xFFFFFFFC.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step();
    applyStimulus(1'b1, 32'hFFFF_FFFC, 1'b1, 32'h1234_5678, 1'b0); step();
    checkOutput("same_cycle", 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0050_0093, 32'd20, 32'hFFFF_FFFC, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h0000_006F, 1'b0); step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    checkOutput("wrap", 1'b1, 32'h0, 1'b0, 32'h0000_006F, 32'hFFFF_FFFC, 32'h0, 1'b0);

    // Misaligned redirect traps; later redirects are ignored until reset.
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'h00A0_0513, 1'b0); step();
    applyStimulus(1'b1, 32'd22, 1'b0, 32'h0, 1'b1); step();
    applyStimulus(1'b1, 32'd8, 1'b1, 32'h0, 1'b1);
    for (int i = 0; i < 3; i++) begin
      checkOutput($sformatf("err%0d", i), 1'b0, 32'h0, 1'b0, 32'h00A0_0513, 32'h0, 32'h0, 1'b1);
      step();
    end
    resetDut();
    checkOutput("err_cleared", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 1'b0);
    step();
    checkOutput("err_restart", 1'b1, 32'h0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 1'b0);

    // Reset while in WAIT, with a response landing in BOOT afterwards.
    step();
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hAAAA_0013, 1'b0); step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b1); step();
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step();
    checkOutput("pre_reset_wait", 1'b0, 32'h4, 1'b0, 32'hAAAA_0013, 32'h0, 32'h4, 1'b0);
    rst = 1'b1;
    #1;
    checkOutput("async_reset", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 1'b0);
    step();
    rst = 1'b0;
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hBBBB_0013, 1'b0); step();
    checkOutput("boot_ignore", 1'b1, 32'h0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b0, 32'h0, 1'b0); step();
    step();
    checkOutput("post_reset_wait", 1'b0, 32'h0, 1'b0, NOP_INSTR, 32'h0, 32'h0, 1'b0);
    applyStimulus(1'b0, 32'h0, 1'b1, 32'hCCCC_0013, 1'b0); step();
    checkOutput("post_reset_hold", 1'b0, 32'h0, 1'b1, 32'hCCCC_0013, 32'h0, 32'h0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
